nes_palette_pipe: RTL and testbench
===================================

NES_PALETTE_PIPE -- requirements
Module: nes_palette_pipe

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 8: output bits per colour channel, legal range 1..8.
REQ-002 SHALL have parameter PAL_DEPTH, default 32: palette RAM entries, a power of two, minimum 32.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1: palette write strobe.
REQ-006 SHALL have port wr_addr, input, $clog2(PAL_DEPTH): palette write address.
REQ-007 SHALL have port wr_data, input, 6: NES colour index to store.
REQ-008 SHALL have port rd_addr, input, $clog2(PAL_DEPTH): CPU read-back address, sampled every cycle.
REQ-009 SHALL have port rd_data, output, 6: registered read-back data.
REQ-010 SHALL have port pix_valid, input, 1: pixel request qualifier.
REQ-011 SHALL have port pix_idx, input, $clog2(PAL_DEPTH): palette index of the pixel.
REQ-012 SHALL have port mask, input, 4: {emph_b, emph_g, emph_r, greyscale}; sampled with each pixel in stage 1.
REQ-013 SHALL have port rgb_out, output, 3*CH_WIDTH: {R,G,B}, with R in the MSBs.
REQ-014 SHALL have port rgb_valid, output, 1: rgb_out qualifier.

Function
REQ-015 SHALL apply address mirroring on all three ports: when addr[4]=1 and addr[1:0]=0, bit 4 is forced to 0 (0x10/14/18/1C map to 0x00/04/08/0C).
REQ-016 SHALL write wr_data to the mirrored wr_addr on a cycle with wr_en=1.
REQ-017 SHALL make reads write-first: a read or pixel lookup hitting the mirrored address being written that cycle returns wr_data.
REQ-018 SHALL present rd_data one cycle after rd_addr is sampled.
REQ-019 SHALL run pixel stage 1 (registered): entry = palette[pix_idx]; when greyscale=1, entry = entry & 6'h30; pix_valid and the emphasis bits travel with the pixel.
REQ-020 SHALL run pixel stage 2 (registered): 24-bit colour = NES master table[entry]; apply emphasis; each channel is then truncated to its CH_WIDTH MSBs.
REQ-021 SHALL apply emphasis as follows: when any emph bit is set, each channel whose own emph bit is 0 becomes x - (x>>2) in 8-bit unsigned arithmetic (no overflow is possible); channels with their bit set are unchanged.
REQ-022 SHALL have a fixed latency of 2: rgb_valid equals pix_valid from 2 cycles earlier; rgb_out is updated only when the stage-2 valid is 1 and otherwise holds its last value.
REQ-023 SHALL accept a new pixel every cycle, with no stall and no backpressure.
REQ-024 SHALL let an index outside the table, or PAL_DEPTH > 32, use only pix_idx[4:0] after mirroring; upper address bits SHALL be ignored.

Reset
REQ-025 SHALL, on Reset=1 at a clock edge, clear all palette entries to 6'h0F, set rd_data=0, rgb_out=0, rgb_valid=0, and clear both pipeline valids.
REQ-026 SHALL give Reset priority over a simultaneous write; pixels in flight when Reset is asserted are discarded.

Configuration
REQ-027 SHALL, when macro NES_PAL_EMPHASIS_EN is defined, implement REQ-021.
REQ-028 SHALL, when NES_PAL_EMPHASIS_EN is undefined, ignore mask[3:1], pass channels unattenuated, and keep latency unchanged.

Structure
REQ-029 SHALL take the 64x24 NES master colour table, the mirror function and the 6'h0F reset constant from package nes_video_pkg.
REQ-030 SHALL implement the palette storage as sub-module nes_palette_ram (1 write port, 2 read ports, write-first, synchronous clear); stage logic stays in the top module.

Verification
REQ-031 SHALL cover: write 0x01->addr 0x01; pix_idx=0x01, mask=0 -> 2 cycles later rgb_out=24'h0000FC, rgb_valid=1.
REQ-032 SHALL cover: write 0x16->addr 0x10; rd_addr=0x00 -> rd_data=0x16 next cycle; pix_idx=0x00 -> 24'hF83800.
REQ-033 SHALL cover: palette[0x02]=0x16, greyscale=1 -> 24'hBCBCBC; with wr_en to 0x02 of 0x20 in the same cycle as the lookup -> 24'hF8F8F8 (write-first).
REQ-034 SHALL cover: entry 0x20, mask=4'b0010 (emph_r), EMPHASIS_EN defined -> 24'hF8BABA; macro undefined -> 24'hF8F8F8.
REQ-035 SHALL cover: CH_WIDTH=4, entry 0x01 -> rgb_out=12'h00F.
REQ-036 SHALL cover: pix_valid=1 for 3 cycles, Reset pulsed in cycle 2 -> rgb_valid never 1 for those pixels; afterwards any index reads 0x0F -> 24'h000000.

Source files
------------

// File: rtl/nes_video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_video_pkg
//  Description : Shared NES video constants. Holds the 64-entry master colour
//                table, the palette address mirror helper and the palette
//                reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package nes_video_pkg;

    // Value every palette entry takes after reset (NES colour index "black").
    localparam logic [5:0] c_pal_reset_val = 6'h0F;

    // Greyscale keeps only the luma row of the colour index.
    localparam logic [5:0] c_grey_mask = 6'h30;

    // 64 x 24-bit master colour table, {R,G,B}; element 0 is the first entry.
    localparam logic [0:63][23:0] c_nes_master = {
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Stage-1 pipeline payload: the looked-up entry plus what travels with it.
    typedef struct packed {
        logic       valid;
        logic [2:0] emph;   // {emph_b, emph_g, emph_r}
        logic [5:0] entry;
    } s1_t;

    // Sprite-0 backdrop mirrors: 0x10/14/18/1C alias 0x00/04/08/0C.
    function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
        logic [4:0] m;
        m = addr;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            m[4] = 1'b0;
        end
        return m;
    endfunction

    // Master table lookup.
    function automatic logic [23:0] nes_master(input logic [5:0] idx);
        return c_nes_master[idx];
    endfunction

    // Emphasis attenuation: x - x/4, cannot underflow in 8 bits.
    function automatic logic [7:0] emph_atten(input logic [7:0] x);
        return x - (x >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nes_palette_ram.sv
`default_nettype none
// ============================================================================
//  Module      : nes_palette_ram
//  Description : 32 x 6-bit palette storage. One write port, two
//                combinational read ports with write-first bypass, and a
//                synchronous clear to the reset colour. Addresses arrive
//                already mirrored.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_palette_ram
    import nes_video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [5:0] wdata,
    input  logic [4:0] raddr_a,
    input  logic [4:0] raddr_b,
    output logic [5:0] rdata_a,
    output logic [5:0] rdata_b
);

    logic [5:0] r_mem [32];

    // Storage update: reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= c_pal_reset_val;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Write-first read ports: a same-cycle write to the read address is forwarded.
    always_comb begin
        rdata_a = r_mem[raddr_a];
        rdata_b = r_mem[raddr_b];
        if (we && (waddr == raddr_a)) rdata_a = wdata;
        if (we && (waddr == raddr_b)) rdata_b = wdata;
    end

endmodule
`default_nettype wire

// File: rtl/nes_palette_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : nes_palette_pipe
//  Description : NES palette RAM with CPU read-back and a two-stage pixel
//                colour pipeline (palette lookup, then master table,
//                emphasis and channel truncation).
//                Build option: define NES_PAL_EMPHASIS_EN to enable colour
//                emphasis; without it mask[3:1] is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_palette_pipe
    import nes_video_pkg::*;
#(
    parameter int CH_WIDTH  = 8,
    parameter int PAL_DEPTH = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  logic [$clog2(PAL_DEPTH)-1:0] wr_addr,
    input  logic [5:0]                   wr_data,
    input  logic [$clog2(PAL_DEPTH)-1:0] rd_addr,
    output logic [5:0]                   rd_data,
    input  logic                         pix_valid,
    input  logic [$clog2(PAL_DEPTH)-1:0] pix_idx,
    input  logic [3:0]                   mask,
    output logic [3*CH_WIDTH-1:0]        rgb_out,
    output logic                         rgb_valid
);

    // Only the low five address bits select a palette entry.
    logic [4:0] w_wr_addr;
    logic [4:0] w_rd_addr;
    logic [4:0] w_pix_addr;
    logic [5:0] w_rd_entry;
    logic [5:0] w_pix_entry;

    assign w_wr_addr  = pal_mirror(wr_addr[4:0]);
    assign w_rd_addr  = pal_mirror(rd_addr[4:0]);
    assign w_pix_addr = pal_mirror(pix_idx[4:0]);

    nes_palette_ram u_ram (
        .clk     (Clk),
        .rst     (Reset),
        .we      (wr_en),
        .waddr   (w_wr_addr),
        .wdata   (wr_data),
        .raddr_a (w_rd_addr),
        .raddr_b (w_pix_addr),
        .rdata_a (w_rd_entry),
        .rdata_b (w_pix_entry)
    );

    s1_t r_s1;

    // CPU read-back register and pixel stage 1 (lookup, greyscale, side data).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_data <= 6'h00;
            r_s1    <= '0;
        end else begin
            rd_data       <= w_rd_entry;
            r_s1.valid    <= pix_valid;
            r_s1.emph     <= mask[3:1];
            r_s1.entry    <= mask[0] ? (w_pix_entry & c_grey_mask) : w_pix_entry;
        end
    end

    // Stage 2 combinational path: master colour, emphasis, truncation.
    logic [23:0]           w_rgb24;
    logic [7:0]            w_r;
    logic [7:0]            w_g;
    logic [7:0]            w_b;
    logic [3*CH_WIDTH-1:0] w_rgb_trunc;

    assign w_rgb24 = nes_master(r_s1.entry);

`ifdef NES_PAL_EMPHASIS_EN
    logic w_any_emph;
    assign w_any_emph = |r_s1.emph;
    // A channel is dimmed when some emphasis is active but not its own.
    assign w_r = (w_any_emph && !r_s1.emph[0]) ? emph_atten(w_rgb24[23:16]) : w_rgb24[23:16];
    assign w_g = (w_any_emph && !r_s1.emph[1]) ? emph_atten(w_rgb24[15:8])  : w_rgb24[15:8];
    assign w_b = (w_any_emph && !r_s1.emph[2]) ? emph_atten(w_rgb24[7:0])   : w_rgb24[7:0];
`else
    logic w_unused_emph;
    assign w_unused_emph = &{1'b0, r_s1.emph};
    assign w_r = w_rgb24[23:16];
    assign w_g = w_rgb24[15:8];
    assign w_b = w_rgb24[7:0];
`endif

    assign w_rgb_trunc = {w_r[7 -: CH_WIDTH], w_g[7 -: CH_WIDTH], w_b[7 -: CH_WIDTH]};

    // Pixel stage 2: output register holds its value on idle cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= r_s1.valid;
            if (r_s1.valid) begin
                rgb_out <= w_rgb_trunc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nes_palette_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nes_palette_pipe
//  Description : Directed self-checking bench for nes_palette_pipe. Drives a
//                full-width instance and a CH_WIDTH=4 instance in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_palette_pipe;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [5:0]  wr_data;
    logic [4:0]  rd_addr;
    logic [5:0]  rd_data;
    logic [5:0]  rd_data4;
    logic        pix_valid;
    logic [4:0]  pix_idx;
    logic [3:0]  mask;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic [11:0] rgb_out4;
    logic        rgb_valid4;

    int n_checks = 0;
    int n_errors = 0;

`ifdef NES_PAL_EMPHASIS_EN
    localparam logic [23:0] c_exp_emph_r  = 24'hF8BABA;
    localparam logic [11:0] c_exp_emph_r4 = 12'hFBB;
`else
    localparam logic [23:0] c_exp_emph_r  = 24'hF8F8F8;
    localparam logic [11:0] c_exp_emph_r4 = 12'hFFF;
`endif

    nes_palette_pipe #(.CH_WIDTH(8), .PAL_DEPTH(32)) u_dut (
        .Clk       (clk),
        .Reset     (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .mask      (mask),
        .rgb_out   (rgb_out),
        .rgb_valid (rgb_valid)
    );

    nes_palette_pipe #(.CH_WIDTH(4), .PAL_DEPTH(32)) u_dut4 (
        .Clk       (clk),
        .Reset     (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data4),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .mask      (mask),
        .rgb_out   (rgb_out4),
        .rgb_valid (rgb_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Single pixel; returns at the cycle its result is visible.
    task automatic pixel(input logic [4:0] idx, input logic [3:0] m);
        pix_valid = 1'b1;
        pix_idx   = idx;
        mask      = m;
        tick();
        pix_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; pix_valid = 1'b0; pix_idx = '0; mask = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rd_data",   32'(rd_data),   32'h0);
        check("rst_rgb_valid", 32'(rgb_valid), 32'h0);
        check("rst_rgb_out",   32'(rgb_out),   32'h0);
        check("rst_rgb_out4",  32'(rgb_out4),  32'h0);

        rd_addr = 5'h05;
        tick();
        check("rst_pal_val", 32'(rd_data), 32'h0F);

        // Basic lookup with exact two-cycle latency.
        pal_write(5'h01, 6'h01);
        pix_valid = 1'b1; pix_idx = 5'h01; mask = 4'b0000;
        tick();
        pix_valid = 1'b0;
        check("lat1_valid", 32'(rgb_valid), 32'h0);
        tick();
        check("lat2_valid", 32'(rgb_valid), 32'h1);
        check("blue_rgb",   32'(rgb_out),   32'h0000FC);
        check("blue_rgb4",  32'(rgb_out4),  32'h00F);
        check("blue_valid4", 32'(rgb_valid4), 32'h1);

        // Mirrored write 0x10 -> 0x00, read back through both aliases.
        pal_write(5'h10, 6'h16);
        rd_addr = 5'h00;
        tick();
        check("mirror_rd0", 32'(rd_data), 32'h16);
        rd_addr = 5'h10;
        tick();
        check("mirror_rd10", 32'(rd_data), 32'h16);
        pixel(5'h00, 4'b0000);
        check("mirror_rgb",  32'(rgb_out),  32'hF83800);
        check("mirror_rgb4", 32'(rgb_out4), 32'hF30);

        // Greyscale.
        pal_write(5'h02, 6'h16);
        pixel(5'h02, 4'b0001);
        check("grey_rgb",  32'(rgb_out),  32'hBCBCBC);
        check("grey_rgb4", 32'(rgb_out4), 32'hBBB);

        // Write-first on both read ports in the same cycle as the write.
        wr_en = 1'b1; wr_addr = 5'h02; wr_data = 6'h20;
        rd_addr = 5'h02;
        pix_valid = 1'b1; pix_idx = 5'h02; mask = 4'b0001;
        tick();
        wr_en = 1'b0; pix_valid = 1'b0;
        check("wf_rd_data", 32'(rd_data), 32'h20);
        tick();
        check("wf_rgb", 32'(rgb_out), 32'hF8F8F8);

        // Emphasis: red only, then all three (nothing dimmed).
        pixel(5'h02, 4'b0010);
        check("emph_r_rgb",  32'(rgb_out),  32'(c_exp_emph_r));
        check("emph_r_rgb4", 32'(rgb_out4), 32'(c_exp_emph_r4));
        pixel(5'h02, 4'b1110);
        check("emph_all_rgb", 32'(rgb_out), 32'hF8F8F8);

        // Back-to-back pixels, then hold on an idle cycle.
        pix_valid = 1'b1; pix_idx = 5'h01; mask = 4'b0000;
        tick();
        pix_idx = 5'h00;
        tick();
        check("b2b_a", 32'(rgb_out), 32'h0000FC);
        pix_idx = 5'h02;
        tick();
        check("b2b_b", 32'(rgb_out), 32'hF83800);
        pix_valid = 1'b0;
        tick();
        check("b2b_c", 32'(rgb_out), 32'hF8F8F8);
        check("b2b_c_valid", 32'(rgb_valid), 32'h1);
        tick();
        check("idle_valid", 32'(rgb_valid), 32'h0);
        check("idle_hold",  32'(rgb_out),   32'hF8F8F8);

        // Reset mid-stream, with a competing write that must lose.
        pix_valid = 1'b1; pix_idx = 5'h01;
        tick();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'h03; wr_data = 6'h30;
        tick();
        check("rstmid_valid1", 32'(rgb_valid), 32'h0);
        check("rstmid_rgb",    32'(rgb_out),   32'h0);
        rst = 1'b0; wr_en = 1'b0;
        tick();
        check("rstmid_valid2", 32'(rgb_valid), 32'h0);
        pix_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(rgb_valid), 32'h1);
        check("post_rst_rgb",   32'(rgb_out),   32'h000000);
        rd_addr = 5'h03;
        tick();
        check("rst_beats_wr", 32'(rd_data), 32'h0F);
        rd_addr = 5'h01;
        tick();
        check("post_rst_rd1", 32'(rd_data), 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
